// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_HOLD   = 3'd6
  } rx_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 32'd2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word and valid/ready pop interface.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q;
  logic             valid_q;
  logic             pop_s, push_s;

  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = valid_q & i_ready;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign push_s  = i_push & (~o_full | pop_s);
  assign o_data  = head_q;
  assign o_valid = valid_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
    else       rd_ptr_d = rd_ptr_q;
    if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else        wr_ptr_d = wr_ptr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      // Head reloads only from words already stored, so a fresh push shows one cycle later.
      if (wr_ptr_q != rd_ptr_d) begin
        valid_q <= 1'b1;
        head_q  <= mem_q[rd_ptr_d[AW-1:0]];
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_s) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Configurable UART receiver: oversampled bit FSM feeding a per-byte status FIFO,
// with sticky overflow and a break pulse.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned BAUD_RATE  = 3_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overflow,
  output logic                 o_break,
  input  logic                 i_clr_err,
  output logic                 o_busy
);

  localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned W     = DATA_BITS + 2;
  localparam logic [1:0]       PAR_SEL  = PARITY[1:0];
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx_frame: baud divisor must be at least 4");
  end

  logic                 rxd_meta_q, rxd_sync_q, rxd_last_q;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q, frame_err_q, push_q, break_q, ovf_q;
  logic [W-1:0]         push_word_q;
  logic [W-1:0]         head_s;
  logic                 tick_s, fall_s, par_err_s, fifo_full_s, pop_s;

  assign tick_s = (cnt_q == {CNT_W{1'b0}});
  assign fall_s = rxd_last_q & ~rxd_sync_q;
  assign pop_s  = o_valid & i_ready;
  // Odd parity wants data^parity == 1, even wants 0.
  assign par_err_s = (PAR_SEL == PAR_ODD)  ? ~(^shift_q ^ par_bit_q) :
                     (PAR_SEL == PAR_EVEN) ?  (^shift_q ^ par_bit_q) : 1'b0;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_last_q <= 1'b1;
    end else begin
      rxd_meta_q <= i_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_last_q <= rxd_sync_q;
    end
  end

  // Frame FSM: bit timing, shifting, error capture, push and break generation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      bit_cnt_q   <= 4'd0;
      shift_q     <= {DATA_BITS{1'b0}};
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= {W{1'b0}};
      break_q     <= 1'b0;
    end else begin
      push_q  <= 1'b0;
      break_q <= 1'b0;
      if (state_q != ST_IDLE && state_q != ST_HOLD) begin
        cnt_q <= tick_s ? CNT_FULL : cnt_q - CNT_ONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (fall_s) begin
            cnt_q   <= CNT_HALF;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick_s) begin
            bit_cnt_q   <= 4'd0;
            par_bit_q   <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= rxd_sync_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            shift_q   <= {rxd_sync_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= (PAR_SEL == PAR_NONE) ? ST_STOP1 : ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (tick_s) begin
            par_bit_q <= rxd_sync_q;
            state_q   <= ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (tick_s) begin
            // Break is decided on STOP1 alone; a low STOP2 is only a framing error.
            if (!rxd_sync_q && shift_q == {DATA_BITS{1'b0}} && !par_bit_q) begin
              break_q <= 1'b1;
              state_q <= ST_HOLD;
            end else if (STOP_BITS == 2) begin
              frame_err_q <= ~rxd_sync_q;
              state_q     <= ST_STOP2;
            end else begin
              push_q      <= 1'b1;
              push_word_q <= {par_err_s, ~rxd_sync_q, shift_q};
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_STOP2: begin
          if (tick_s) begin
            push_q      <= 1'b1;
            push_word_q <= {par_err_s, frame_err_q | ~rxd_sync_q, shift_q};
            state_q     <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (rxd_sync_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow; a same-cycle set beats the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                   ovf_q <= 1'b0;
    else if (push_q && fifo_full_s && !pop_s)    ovf_q <= 1'b1;
    else if (i_clr_err)                          ovf_q <= 1'b0;
  end

  sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_q),
    .i_data  (push_word_q),
    .o_data  (head_s),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_full  (fifo_full_s)
  );

  assign o_data       = head_s[DATA_BITS-1:0];
  assign o_frame_err  = head_s[DATA_BITS];
  assign o_parity_err = head_s[DATA_BITS+1];
  assign o_overflow   = ovf_q;
  assign o_break      = break_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised, synthesizable UART receiver with a per-byte status FIFO. It replaces the fixed 8N1 behavioural monitor in SoC benches and can also sit on-chip behind `o_txd`-style serial lines. Data width, parity mode, stop-bit count, baud divisor and buffer depth are all configurable. Framing errors, parity errors, line breaks and overflow are reported per byte or as sticky flags.

## Interface
- `CLK_HZ`, 12_000_000: input clock frequency.
- `BAUD_RATE`, 3_000_000: line rate. `DIV = CLK_HZ/BAUD_RATE` is rounded to nearest and must be ≥ 4 (elaboration assertion).
- `DATA_BITS`, 8: payload bits per frame, range 5..9, LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: power of two, ≥ 2.
- `i_clk`, in, 1: single clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_rxd`, in, 1: asynchronous serial input, idle high.
- `o_data`, out, DATA_BITS: FIFO head payload.
- `o_frame_err`, out, 1: FIFO head had a bad stop bit.
- `o_parity_err`, out, 1: FIFO head failed the parity check (always 0 when PARITY = 0).
- `o_valid`, out, 1: FIFO non-empty.
- `i_ready`, in, 1: consumer accepts the head; pop occurs when `o_valid && i_ready`.
- `o_overflow`, out, 1: sticky; set when a frame completes while the FIFO is full.
- `o_break`, out, 1: one-cycle pulse on break detection.
- `i_clr_err`, in, 1: clears `o_overflow`.
- `o_busy`, out, 1: FSM not in IDLE.

## Operation
- `i_rxd` passes through a 2-flop synchronizer; the sync register resets to 1.
- FSM states: IDLE → START → DATA → [PARITY] → STOP1 → [STOP2] → IDLE. Bracketed states exist only when enabled.
- IDLE: a synchronized falling edge loads the bit counter with `DIV/2 - 1` and moves to START.
- START: at counter zero, samples the line. Low → reload `DIV-1` and go to DATA. High → glitch; return to IDLE and push nothing.
- DATA: samples on every counter expiry and shifts right into the shift register; after DATA_BITS samples, moves on.
- PARITY: the sampled bit is XORed with the payload. Odd mode expects the total to be 1; even mode expects 0.
- STOP1/STOP2: a low sample sets the frame-error bit.
- Push: on the last stop sample, the FIFO receives {parity_err, frame_err, data}.
- Full FIFO: the word is dropped, `o_overflow` is set, and FIFO contents are unchanged.
- Break: payload all zero, parity bit (if any) zero and STOP1 low. `o_break` pulses, no word is pushed, and the FSM waits in IDLE-HOLD until the synchronized line is high before re-arming.
- STOP2 low alone is a normal frame error, not a break.
- FIFO: simultaneous push and pop on a full FIFO is legal; the pop frees the slot, the push succeeds, and there is no overflow.
- `i_clr_err` and a same-cycle overflow event: the set wins.

## Timing
- Reset values:
  - `o_valid` = 0, `o_data` = 0, `o_frame_err` = 0, `o_parity_err` = 0.
  - `o_overflow` = 0, `o_break` = 0, `o_busy` = 0.
  - FIFO empty, FSM IDLE, synchronizer = 1.
- Reset asserted mid-frame: the partial frame is discarded and nothing is pushed.
- Start detection: 2 cycles after `i_rxd` falls (synchronizer latency).
- Sample points: 2 + `DIV/2` cycles after the edge, then every `DIV` cycles. Mid-bit tolerance is ±(DIV/2 − 1) cycles.
- Push: the cycle after the last stop sample. `o_valid` rises 1 cycle after the push into an empty FIFO (registered FIFO outputs).
- Throughput: back-to-back frames with no idle gap are supported. START re-arms in the cycle after the push.
- FIFO pointers: `$clog2(FIFO_DEPTH)+1` bits; wrap-around is handled by the MSB compare.

## Structure
- Package `uart_pkg`:
  - parity enum (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`).
  - FSM state enum.
  - function `baud_div(clk_hz, baud)`.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`): valid/ready output, `o_full`, registered head. Reusable by a future TX block.

## Test plan
- 12 MHz / 3 Mbaud (DIV = 4), 8N1: send 0x55 then 0xA3 back-to-back → two pops 0x55, 0xA3, both error bits 0, no overflow.
- PARITY = 2, send 0x07 with parity bit 0 (wrong) → pop 0x07, `o_parity_err` = 1. Resend with parity bit 1 → `o_parity_err` = 0.
- STOP_BITS = 2, frame 0x3C with STOP2 low → pop 0x3C, `o_frame_err` = 1, `o_break` = 0.
- Hold `i_ready` = 0 and send 17 bytes 0x00..0x10 (FIFO_DEPTH = 16) → 16 entries 0x00..0x0F retained, `o_overflow` = 1. Pulse `i_clr_err` → `o_overflow` = 0.
- Hold `i_rxd` low for 3 frame times → exactly one `o_break` pulse, no push. Then send 0x81 after the line returns high → pop 0x81.
- Robustness:
  - 1-cycle low glitch on `i_rxd` → `o_busy` returns to 0 and nothing is pushed.
  - Assert `i_rst` during DATA of byte 0x42 → FIFO empty, and the next clean byte 0x99 is received correctly.
